// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers, one bit per cycle.
// Define MDU_DIV_EN to compile in the restoring divider; without it divide ops complete as no-ops.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mc_q, mc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
`ifdef MDU_DIV_EN
  logic               rneg_q, rneg_d, bz_q, bz_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic [WIDTH:0]     r_sh, diff;
  logic [2*WIDTH-1:0] div_nxt;
`endif

  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt, prod_neg;

  always_comb begin
    // Magnitudes as unsigned WIDTH-bit values: |MIN| = 2^(WIDTH-1) is still exact.
    sgn      = ~op[0];
    a_neg    = sgn & a[WIDTH-1];
    b_neg    = sgn & b[WIDTH-1];
    a_mag    = a_neg ? (~a) + 1'b1 : a;
    b_mag    = b_neg ? (~b) + 1'b1 : b;
    // Shift-add: p holds {partial product high half, remaining multiplier bits}.
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mc_q & {WIDTH{p_q[0]}}};
    mul_nxt  = {mul_sum, p_q[WIDTH-1:1]};
    prod_neg = (~p_q) + 1'b1;
`ifdef MDU_DIV_EN
    // Restoring divide: p holds {remainder, dividend/quotient shift register}.
    r_sh     = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    diff     = r_sh - {1'b0, mc_q};
    div_nxt  = diff[WIDTH] ? {r_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    araw_d   = araw_q;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    mc_d    = mc_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        op_d   = op;
        neg_d  = a_neg ^ b_neg;
        busy_d = 1'b1;
        cnt_d  = '0;
        mc_d   = a_mag;
        p_d    = {{WIDTH{1'b0}}, b_mag};
`ifdef MDU_DIV_EN
        rneg_d  = a_neg;
        bz_d    = (b == '0);
        araw_d  = a;
        state_d = CALC;
        if (op[1]) begin
          mc_d = b_mag;
          p_d  = {{WIDTH{1'b0}}, a_mag};
        end
`else
        state_d = op[1] ? FIX : CALC;
`endif
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
`ifdef MDU_DIV_EN
        p_d = op_q[1] ? div_nxt : mul_nxt;
`else
        p_d = mul_nxt;
`endif
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        if (!op_q[1]) begin
          {hi_d, lo_d} = neg_q ? prod_neg : p_q;
        end
`ifdef MDU_DIV_EN
        else if (bz_q) begin
          lo_d  = '1;
          hi_d  = araw_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = neg_q  ? prod_neg[WIDTH-1:0] : p_q[WIDTH-1:0];
          hi_d = rneg_q ? (~p_q[2*WIDTH-1:WIDTH]) + 1'b1 : p_q[2*WIDTH-1:WIDTH];
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mc_q    <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef MDU_DIV_EN
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      araw_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      mc_q    <= mc_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
`ifdef MDU_DIV_EN
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      araw_q  <= araw_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
endmodule
